// File: rtl/exc_seq.sv
// Exception/ERET sequencer: drives read-modify-write sequences on CP0 over one read and
// one write port, then issues a one-cycle flush/redirect to fetch.
module exc_seq #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          CP0_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_delay_slot,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  badvaddr_valid,
  input  logic                  eret_valid,
  output logic [CP0_ADDR_W-1:0] cp0_read_addr,
  input  logic [31:0]           cp0_read_data,
  output logic                  cp0_write_en,
  output logic [CP0_ADDR_W-1:0] cp0_write_addr,
  output logic [31:0]           cp0_write_data,
  output logic                  busy,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc
);

  localparam logic [CP0_ADDR_W-1:0] ADDR_BADV   = CP0_ADDR_W'(8);
  localparam logic [CP0_ADDR_W-1:0] ADDR_STATUS = CP0_ADDR_W'(12);
  localparam logic [CP0_ADDR_W-1:0] ADDR_CAUSE  = CP0_ADDR_W'(13);
  localparam logic [CP0_ADDR_W-1:0] ADDR_EPC    = CP0_ADDR_W'(14);

  typedef enum logic [3:0] {
    IDLE, E_RD_ST, E_RD_CA, E_WR_EPC, E_WR_BADV, E_WR_CAUSE, E_WR_ST,
    R_RD_EPC, R_RD_ST, R_WR_ST, REDIR
  } state_t;

  state_t state, state_next;

  // Request and CP0 snapshot captured over the sequence.
  logic        is_eret;
  logic [4:0]  code;
  logic [31:0] pc;
  logic        ds;
  logic [31:0] badv;
  logic        bv;
  logic [31:0] st_old;
  logic        exl_old;
  logic [31:7] ca_hi;
  logic [1:0]  ca_lo;
  logic        ca_bd;
  logic [31:0] epc;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_eret <= 1'b0;
      code    <= '0;
      pc      <= '0;
      ds      <= 1'b0;
      badv    <= '0;
      bv      <= 1'b0;
      st_old  <= '0;
      exl_old <= 1'b0;
      ca_hi   <= '0;
      ca_lo   <= '0;
      ca_bd   <= 1'b0;
      epc     <= '0;
    end else begin
      case (state)
        IDLE: if (exc_valid || eret_valid) begin
          is_eret <= !exc_valid;
          code    <= exc_code;
          pc      <= exc_pc;
          ds      <= exc_delay_slot;
          badv    <= exc_badvaddr;
          bv      <= badvaddr_valid;
        end
        E_RD_ST: begin
          st_old  <= cp0_read_data;
          exl_old <= cp0_read_data[1];
        end
        E_RD_CA: begin
          ca_bd <= cp0_read_data[31];
          ca_hi <= cp0_read_data[31:7];
          ca_lo <= cp0_read_data[1:0];
        end
        R_RD_EPC: epc    <= cp0_read_data;
        R_RD_ST:  st_old <= cp0_read_data;
        default: ;
      endcase
    end
  end

  // Skipped writes fall straight through to the next live state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (exc_valid)       state_next = E_RD_ST;
        else if (eret_valid) state_next = R_RD_EPC;
      end
      E_RD_ST:    state_next = E_RD_CA;
      E_RD_CA: begin
        if (!exl_old) state_next = E_WR_EPC;
        else if (bv)  state_next = E_WR_BADV;
        else          state_next = E_WR_CAUSE;
      end
      E_WR_EPC:   state_next = bv ? E_WR_BADV : E_WR_CAUSE;
      E_WR_BADV:  state_next = E_WR_CAUSE;
      E_WR_CAUSE: state_next = E_WR_ST;
      E_WR_ST:    state_next = REDIR;
      R_RD_EPC:   state_next = R_RD_ST;
      R_RD_ST:    state_next = R_WR_ST;
      R_WR_ST:    state_next = REDIR;
      REDIR:      state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    cp0_read_addr  = '0;
    cp0_write_en   = 1'b0;
    cp0_write_addr = '0;
    cp0_write_data = '0;
    busy           = (state != IDLE);
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      E_RD_ST, R_RD_ST: cp0_read_addr = ADDR_STATUS;
      E_RD_CA:          cp0_read_addr = ADDR_CAUSE;
      R_RD_EPC:         cp0_read_addr = ADDR_EPC;
      E_WR_EPC: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_EPC;
        cp0_write_data = ds ? pc - 32'd4 : pc;
      end
      E_WR_BADV: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_BADV;
        cp0_write_data = badv;
      end
      E_WR_CAUSE: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_CAUSE;
        cp0_write_data = {(exl_old ? ca_bd : ds), ca_hi[30:7], code, ca_lo};
      end
      E_WR_ST: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_STATUS;
        cp0_write_data = st_old | 32'h2;
      end
      R_WR_ST: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_STATUS;
        cp0_write_data = st_old & ~32'h2;
      end
      REDIR: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = is_eret ? epc : EXC_VECTOR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: a CP0 register-file model answers reads; each sequence is compared
// with the write list, latency and redirect predicted from the architectural rules.
module tb_exc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, eret_valid, exc_delay_slot, badvaddr_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badvaddr;
  logic [4:0]  cp0_read_addr, cp0_write_addr;
  logic [31:0] cp0_read_data, cp0_write_data, redirect_pc;
  logic        cp0_write_en, busy, flush, redirect_valid;

  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  assign cp0_read_data = regs[cp0_read_addr];

  always #5 clk = ~clk;

  exc_seq dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_delay_slot(exc_delay_slot), .exc_badvaddr(exc_badvaddr),
    .badvaddr_valid(badvaddr_valid), .eret_valid(eret_valid),
    .cp0_read_addr(cp0_read_addr), .cp0_read_data(cp0_read_data),
    .cp0_write_en(cp0_write_en), .cp0_write_addr(cp0_write_addr),
    .cp0_write_data(cp0_write_data), .busy(busy), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic check_idle_outputs(input string name);
    logic [72:0] got;
    got = {cp0_read_addr, cp0_write_en, cp0_write_addr, cp0_write_data, busy, flush,
           redirect_valid, redirect_pc[0]};
    checks++;
    if (got !== '0 || redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL %s: outputs not all zero (bits=%h redirect_pc=%h)", name, got, redirect_pc);
    end
  endtask

  // Runs one request (caller is at a negedge) and checks it against the predicted outcome.
  task automatic do_seq(input string name, input bit exc, input bit eret, input logic [4:0] code,
                        input logic [31:0] pc, input bit ds, input logic [31:0] badv,
                        input bit bv, input bit pulse);
    logic [36:0] exp_q[$];
    logic [36:0] got_q[$];
    logic [31:0] st, ca, exp_pc, got_pc;
    logic        bd, got_flush;
    int          lat, redir_cyc, busy_cnt;
    st = regs[12];
    ca = regs[13];
    got_pc = '0;
    got_flush = 1'b0;
    if (exc) begin
      if (!st[1]) exp_q.push_back({5'd14, ds ? pc - 32'd4 : pc});
      if (bv)     exp_q.push_back({5'd8, badv});
      bd = st[1] ? ca[31] : ds;
      exp_q.push_back({5'd13, (ca & 32'h7FFF_FF83) | (32'(code) << 2) | (32'(bd) << 31)});
      exp_q.push_back({5'd12, st | 32'h2});
      lat    = exp_q.size() + 3;
      exp_pc = 32'hBFC0_0380;
    end else begin
      exp_q.push_back({5'd12, st & ~32'h2});
      lat    = 4;
      exp_pc = regs[14];
    end

    exc_valid = exc; eret_valid = eret; exc_code = code; exc_pc = pc;
    exc_delay_slot = ds; exc_badvaddr = badv; badvaddr_valid = bv;
    @(posedge clk);
    #1 exc_valid = 1'b0; eret_valid = 1'b0;

    redir_cyc = 0;
    busy_cnt  = 0;
    for (int n = 1; n <= 12 && redir_cyc == 0; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (cp0_write_en) begin
        got_q.push_back({cp0_write_addr, cp0_write_data});
        regs[cp0_write_addr] = cp0_write_data;
      end
      if (redirect_valid) begin
        redir_cyc = n;
        got_pc    = redirect_pc;
        got_flush = flush;
      end
      exc_valid  = pulse && (n == 2);
      eret_valid = pulse && (n == 2);
    end
    exc_valid = 1'b0; eret_valid = 1'b0;

    checks++;
    if (redir_cyc != lat) begin
      errors++;
      $display("FAIL %s latency: got cycle %0d, expected %0d (0 = timeout)", name, redir_cyc, lat);
    end
    checks++;
    if (got_pc !== exp_pc || got_flush !== 1'b1) begin
      errors++;
      $display("FAIL %s redirect: pc=%h flush=%b, expected pc=%h flush=1", name, got_pc, got_flush, exp_pc);
    end
    checks++;
    if (busy_cnt != lat) begin
      errors++;
      $display("FAIL %s busy: %0d cycles, expected %0d", name, busy_cnt, lat);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s write %0d: got reg %0d=%h, expected reg %0d=%h", name, i,
                 got_q[i][36:32], got_q[i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
      end
    end

    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s post-redirect idle: busy=%b redirect_valid=%b, expected 0/0", name, busy, redirect_valid);
    end
  endtask

  task automatic expect_reg(input string name, input int idx, input logic [31:0] exp);
    checks++;
    if (regs[idx] !== exp) begin
      errors++;
      $display("FAIL %s: reg %0d=%h, expected %h", name, idx, regs[idx], exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    exc_valid = 1'b0; eret_valid = 1'b0; exc_code = '0; exc_pc = '0;
    exc_delay_slot = 1'b0; exc_badvaddr = '0; badvaddr_valid = 1'b0;
    foreach (regs[i]) regs[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("after reset release");
  endtask

  task automatic test_exc_directed;
    regs[12] = 32'h0; regs[13] = 32'h0000_0400; regs[14] = 32'hDEAD_0000; regs[8] = 32'h0;
    do_seq("exc all writes", 1, 0, 5'd4, 32'h8000_0010, 0, 32'h1234_5679, 1, 0);
    expect_reg("t1 EPC", 14, 32'h8000_0010);
    expect_reg("t1 BadVAddr", 8, 32'h1234_5679);
    expect_reg("t1 Cause", 13, 32'h0000_0410);
    expect_reg("t1 Status", 12, 32'h0000_0002);

    regs[12] = 32'h0; regs[13] = 32'h0; regs[8] = 32'hAAAA_5555;
    do_seq("exc delay slot", 1, 0, 5'd4, 32'h8000_0020, 1, 32'hFFFF_0000, 0, 0);
    expect_reg("t2 EPC", 14, 32'h8000_001C);
    expect_reg("t2 Cause", 13, 32'h8000_0010);
    expect_reg("t2 BadVAddr untouched", 8, 32'hAAAA_5555);

    regs[12] = 32'h3; regs[13] = 32'h8000_0000; regs[14] = 32'h1111_2222;
    do_seq("exc nested exl", 1, 0, 5'd8, 32'h8000_0040, 0, 32'h0, 0, 0);
    expect_reg("t3 EPC untouched", 14, 32'h1111_2222);
    expect_reg("t3 Cause BD kept", 13, 32'h8000_0020);
    expect_reg("t3 Status", 12, 32'h0000_0003);
  endtask

  task automatic test_eret;
    regs[14] = 32'h8000_0100; regs[12] = 32'h0000_FF03;
    do_seq("eret", 0, 1, 5'd0, 32'h0, 0, 32'h0, 0, 0);
    expect_reg("t4 Status", 12, 32'h0000_FF01);
  endtask

  task automatic test_priority_and_ignore;
    regs[12] = 32'h0000_0010; regs[13] = 32'h0000_FF00; regs[14] = 32'h8000_0200;
    do_seq("both valid", 1, 1, 5'd0, 32'h8000_0300, 0, 32'h0, 1, 1);
    expect_reg("t5 Status", 12, 32'h0000_0012);
  endtask

  task automatic test_reset_mid;
    regs[12] = 32'h0; regs[13] = 32'h0;
    exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h8000_0500;
    exc_delay_slot = 1'b0; exc_badvaddr = 32'h5; badvaddr_valid = 1'b1;
    @(posedge clk);
    #1 exc_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (cp0_write_en !== 1'b1 || cp0_write_addr !== 5'd13) begin
      errors++;
      $display("FAIL mid reset setup: write_en=%b addr=%0d, expected 1/13", cp0_write_en, cp0_write_addr);
    end
    rst = 1'b0;
    #1 check_idle_outputs("async reset in E_WR_CAUSE");
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (cp0_write_en !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL held reset: write_en=%b busy=%b, expected 0/0", cp0_write_en, busy);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    expect_reg("t6 Status untouched", 12, 32'h0);
    regs[14] = 32'h8000_0600; regs[12] = 32'h0000_0007;
    do_seq("eret after reset", 0, 1, 5'd0, 32'h0, 0, 32'h0, 0, 0);
    expect_reg("t6 Status", 12, 32'h0000_0005);
  endtask

  task automatic test_random;
    int op;
    for (int it = 0; it < 60; it++) begin
      regs[8]  = $urandom; regs[12] = $urandom;
      regs[13] = $urandom; regs[14] = $urandom;
      op = $urandom_range(0, 2);
      do_seq($sformatf("random %0d", it), op != 1, op != 0, 5'($urandom), $urandom,
             1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_exc_directed;
    test_eret;
    test_priority_and_ignore;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
